// File: rtl/ed_pkg.sv
// Shared definitions for the energy-detection result packer: state encoding,
// default word width and trailer field layout.
package ed_pkg;

  localparam int WORD_W_DEF = 32;
  localparam int DEC_W_DEF  = 1;

  typedef logic [2:0] state_t;

  localparam state_t S_IDLE    = 3'd0;
  localparam state_t S_POP     = 3'd1;
  localparam state_t S_CAPTURE = 3'd2;
  localparam state_t S_EMIT    = 3'd3;
  localparam state_t S_FLUSH   = 3'd4;
  localparam state_t S_TRAILER = 3'd5;

  // Trailer word: frame sequence number in the upper half, entry count below.
  localparam int TRL_FIELD_W = 16;
  localparam int TRL_SEQ_LSB = 16;
  localparam int TRL_CNT_LSB = 0;

endpackage

// File: rtl/ed_pack_shiftreg.sv
// Slot-addressed packing register: each write lands in the next free slot,
// LSB first. full flags the write that completes the word.
module ed_pack_shiftreg
  import ed_pkg::*;
#(
  parameter int DEC_W  = DEC_W_DEF,
  parameter int WORD_W = WORD_W_DEF,
  parameter int CNT_W  = $clog2(WORD_W / DEC_W + 1)
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              clear,
  input  logic              wr_en,
  input  logic [DEC_W-1:0]  wr_data,
  output logic [WORD_W-1:0] data,
  output logic [CNT_W-1:0]  cnt,
  output logic              full
);

  localparam int ENTRIES = WORD_W / DEC_W;

  always_ff @(posedge clock) begin
    if (reset || clear) begin
      data <= '0;
      cnt  <= '0;
    end else if (wr_en) begin
      for (int i = 0; i < ENTRIES; i++) begin
        if (cnt == CNT_W'(i)) data[i*DEC_W +: DEC_W] <= wr_data;
      end
      cnt <= cnt + CNT_W'(1);
    end
  end

  assign full = wr_en && (cnt == CNT_W'(ENTRIES - 1));

endmodule

// File: rtl/ed_result_packer.sv
// Packs fout detection results into WORD_W-bit words on a valid/ready stream.
// Optional frame trailer word enabled by defining ED_PACK_TRAILER_EN.
module ed_result_packer
  import ed_pkg::*;
#(
  parameter int DEC_W  = DEC_W_DEF,
  parameter int WORD_W = WORD_W_DEF
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              empty_fout,
  input  logic [DEC_W-1:0]  dout_fout,
  input  logic              end_sig,
  output logic              pop_fout,
  output logic [WORD_W-1:0] word_data,
  output logic              word_valid,
  output logic              word_last,
  input  logic              word_ready,
  output logic              busy,
  output logic              ovf_err
);

  localparam int ENTRIES_PER_WORD = WORD_W / DEC_W;
  localparam int CNT_W            = $clog2(ENTRIES_PER_WORD + 1);

  state_t            state, state_nxt;
  logic              pend, pend_clr, from_flush;
  logic              sr_clear, sr_write, sr_full;
  logic [CNT_W-1:0]  cnt;
  logic [WORD_W-1:0] sr_data;

  ed_pack_shiftreg #(
    .DEC_W  (DEC_W),
    .WORD_W (WORD_W),
    .CNT_W  (CNT_W)
  ) u_shiftreg (
    .clock   (clock),
    .reset   (reset),
    .clear   (sr_clear),
    .wr_en   (sr_write),
    .wr_data (dout_fout),
    .data    (sr_data),
    .cnt     (cnt),
    .full    (sr_full)
  );

`ifdef ED_PACK_TRAILER_EN
  logic [TRL_FIELD_W-1:0] seq, frame_cnt;
  logic [WORD_W-1:0]      trailer_word;

  always_ff @(posedge clock) begin
    if (reset) begin
      seq       <= '0;
      frame_cnt <= '0;
    end else if (state == S_TRAILER && word_ready) begin
      seq       <= seq + 1'b1;
      frame_cnt <= '0;
    end else if (state == S_CAPTURE && frame_cnt != '1) begin
      frame_cnt <= frame_cnt + 1'b1;
    end
  end

  always_comb begin
    trailer_word = '0;
    trailer_word[TRL_SEQ_LSB +: TRL_FIELD_W] = seq;
    trailer_word[TRL_CNT_LSB +: TRL_FIELD_W] = frame_cnt;
  end
`endif

  always_ff @(posedge clock) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nxt;
  end

  // Queued results always win over a pending frame end so they join the frame.
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: begin
        if (!empty_fout)                 state_nxt = S_POP;
        else if (pend && cnt != '0)      state_nxt = S_FLUSH;
`ifdef ED_PACK_TRAILER_EN
        else if (pend)                   state_nxt = S_TRAILER;
`endif
      end
      S_POP:     state_nxt = S_CAPTURE;
      S_CAPTURE: state_nxt = sr_full ? S_EMIT : S_IDLE;
      S_EMIT: begin
`ifdef ED_PACK_TRAILER_EN
        if (word_ready) state_nxt = from_flush ? S_TRAILER : S_IDLE;
`else
        if (word_ready) state_nxt = S_IDLE;
`endif
      end
      S_FLUSH:   state_nxt = S_EMIT;
`ifdef ED_PACK_TRAILER_EN
      S_TRAILER: if (word_ready) state_nxt = S_IDLE;
`endif
      default:   state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    pop_fout   = (state == S_POP);
    sr_write   = (state == S_CAPTURE);
    sr_clear   = (state == S_EMIT) && word_ready;
    busy       = (state != S_IDLE);
    pend_clr   = (state == S_FLUSH) || (state == S_IDLE && empty_fout && cnt == '0);
    word_data  = sr_data;
`ifdef ED_PACK_TRAILER_EN
    word_valid = (state == S_EMIT) || (state == S_TRAILER);
    word_last  = (state == S_TRAILER);
    if (state == S_TRAILER) word_data = trailer_word;
`else
    word_valid = (state == S_EMIT);
    word_last  = (state == S_EMIT) && from_flush;
`endif
  end

  // A second end before the first is serviced merges frames and is flagged.
  always_ff @(posedge clock) begin
    if (reset) begin
      pend       <= 1'b0;
      ovf_err    <= 1'b0;
      from_flush <= 1'b0;
    end else begin
      if (end_sig && pend) ovf_err <= 1'b1;
      if (end_sig)       pend <= 1'b1;
      else if (pend_clr) pend <= 1'b0;
      if (state == S_FLUSH)                   from_flush <= 1'b1;
      else if (state == S_EMIT && word_ready) from_flush <= 1'b0;
    end
  end

endmodule

// File: tb/tb_ed_result_packer.sv
// Randomized self-checking bench for ed_result_packer against a frame-level
// packing model; covers ED_PACK_TRAILER_EN when that macro is defined.
module tb_ed_result_packer;

  typedef struct {
    logic [31:0] data;
    logic        last;
  } exp_t;

  logic        clock;
  logic        reset;
  logic        empty_fout;
  logic [0:0]  dout_fout;
  logic        end_sig;
  logic        pop_fout;
  logic [31:0] word_data;
  logic        word_valid;
  logic        word_last;
  logic        word_ready;
  logic        busy;
  logic        ovf_err;

  logic        push_en;
  logic        push_bit;
  logic        rand_ready;
  logic        fifo_q[$];
  exp_t        exp_q[$];

  int          checkCount;
  int          failCount;
  int          popCount;

  // model state: word being assembled, entries in frame, trailer sequence
  logic [31:0] modelWord;
  int          modelSlot;
  int          modelFrameN;
  int          modelSeq;

  ed_result_packer #(.DEC_W(1), .WORD_W(32)) dut (
    .clock      (clock),
    .reset      (reset),
    .empty_fout (empty_fout),
    .dout_fout  (dout_fout),
    .end_sig    (end_sig),
    .pop_fout   (pop_fout),
    .word_data  (word_data),
    .word_valid (word_valid),
    .word_last  (word_last),
    .word_ready (word_ready),
    .busy       (busy),
    .ovf_err    (ovf_err)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checkCount++;
    if (observed !== expected) begin
      failCount++;
      $display("[TB] FAIL %s observed=%h expected=%h at %0t", tag, observed, expected, $time);
    end
  endtask

  // fout FIFO model: read data appears the cycle after the pop strobe
  initial begin
    forever begin
      @(posedge clock);
      if (reset) begin
        fifo_q.delete();
        empty_fout <= 1'b1;
        dout_fout  <= '0;
      end else begin
        if (pop_fout) begin
          if (fifo_q.size() > 0) dout_fout <= fifo_q.pop_front();
          else                   dout_fout <= '0;
        end
        if (push_en) fifo_q.push_back(push_bit);
        empty_fout <= (fifo_q.size() == 0);
      end
    end
  end

  // output monitor: every valid cycle must show the next predicted word
  initial begin
    forever begin
      @(negedge clock);
      if (!reset) begin
        if (pop_fout) begin
          popCount++;
          checkOutput("pop_while_empty", {31'd0, empty_fout}, 32'd0);
          checkOutput("pop_while_valid", {31'd0, word_valid}, 32'd0);
        end
        if (word_valid) begin
          if (exp_q.size() == 0) begin
            checkOutput("unexpected_word", word_data, 32'hxxxx_xxxx);
          end else begin
            checkOutput("word_data", word_data, exp_q[0].data);
            checkOutput("word_last", {31'd0, word_last}, {31'd0, exp_q[0].last});
            if (word_ready) void'(exp_q.pop_front());
          end
        end
      end
    end
  end

  initial begin
    #900000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic step();
    @(posedge clock);
    #1;
    if (rand_ready) word_ready = ($urandom_range(0, 3) != 0);
  endtask

  task automatic modelReset();
    modelWord   = '0;
    modelSlot   = 0;
    modelFrameN = 0;
    modelSeq    = 0;
  endtask

  task automatic modelEntry(input logic b);
    modelWord[modelSlot] = b;
    modelSlot++;
    modelFrameN++;
    if (modelSlot == 32) begin
      exp_q.push_back('{data: modelWord, last: 1'b0});
      modelWord = '0;
      modelSlot = 0;
    end
  endtask

  task automatic modelEnd();
    logic [15:0] seqField;
    logic [15:0] cntField;
`ifdef ED_PACK_TRAILER_EN
    if (modelSlot > 0) exp_q.push_back('{data: modelWord, last: 1'b0});
    seqField = 16'(modelSeq);
    cntField = (modelFrameN > 65535) ? 16'hFFFF : 16'(modelFrameN);
    exp_q.push_back('{data: {seqField, cntField}, last: 1'b1});
    modelSeq++;
`else
    seqField = '0;
    cntField = '0;
    if (modelSlot > 0) exp_q.push_back('{data: modelWord | {seqField, cntField}, last: 1'b1});
`endif
    modelWord   = '0;
    modelSlot   = 0;
    modelFrameN = 0;
  endtask

  // mode 0 random bits, 1 all ones, 2 alternating starting with 1
  task automatic applyStimulus(input int n, input int mode);
    logic b;
    for (int i = 0; i < n; i++) begin
      case (mode)
        1:       b = 1'b1;
        2:       b = (i % 2 == 0);
        default: b = 1'($urandom_range(0, 1));
      endcase
      push_en  = 1'b1;
      push_bit = b;
      modelEntry(b);
      step();
    end
    push_en = 1'b0;
  endtask

  task automatic sendEnd();
    end_sig = 1'b1;
    modelEnd();
    step();
    end_sig = 1'b0;
  endtask

  task automatic waitIdle(input string tag);
    int quiet = 0;
    for (int c = 0; c < 3000 && quiet < 3; c++) begin
      step();
      if (exp_q.size() == 0 && fifo_q.size() == 0 && !busy) quiet++;
      else quiet = 0;
    end
    if (quiet < 3) checkOutput({tag, "_drain_timeout"}, 32'd1, 32'd0);
  endtask

  task automatic waitValid(input string tag);
    int c = 0;
    while (!word_valid && c < 500) begin
      step();
      c++;
    end
    if (!word_valid) checkOutput({tag, "_valid_timeout"}, 32'd0, 32'd1);
  endtask

  initial begin
    int popBase;
    checkCount = 0;
    failCount  = 0;
    popCount   = 0;
    reset      = 1'b1;
    push_en    = 1'b0;
    push_bit   = 1'b0;
    end_sig    = 1'b0;
    word_ready = 1'b1;
    rand_ready = 1'b0;
    modelReset();
    repeat (3) step();

    checkOutput("rst_pop",   {31'd0, pop_fout},   32'd0);
    checkOutput("rst_valid", {31'd0, word_valid}, 32'd0);
    checkOutput("rst_last",  {31'd0, word_last},  32'd0);
    checkOutput("rst_data",  word_data,           32'd0);
    checkOutput("rst_busy",  {31'd0, busy},       32'd0);
    checkOutput("rst_ovf",   {31'd0, ovf_err},    32'd0);
    reset = 1'b0;
    step();

    $display("[TB] two frames of 40 entries");
    for (int f = 0; f < 2; f++) begin
      applyStimulus(40, 0);
      sendEnd();
      waitIdle("frame40");
    end

    $display("[TB] 32 alternating entries then end");
    applyStimulus(32, 2);
    sendEnd();
    waitIdle("alt32");

    $display("[TB] 5 ones then end");
    popBase = popCount;
    applyStimulus(5, 1);
    sendEnd();
    waitIdle("ones5");
    checkOutput("ones5_pops", 32'(popCount - popBase), 32'd5);

    $display("[TB] back-pressure for 20 cycles");
    word_ready = 1'b0;
    applyStimulus(40, 0);
    waitValid("bp");
    for (int i = 0; i < 20; i++) begin
      step();
      checkOutput("bp_hold_valid", {31'd0, word_valid}, 32'd1);
      checkOutput("bp_no_pop",     {31'd0, pop_fout},   32'd0);
    end
    word_ready = 1'b1;
    step();
    checkOutput("bp_accepted", {31'd0, word_valid}, 32'd0);
    sendEnd();
    waitIdle("bp");

    $display("[TB] end while entries still queued");
    applyStimulus(5, 1);
    sendEnd();
    waitIdle("queued");

    $display("[TB] double end during EMIT");
    checkOutput("ovf_before", {31'd0, ovf_err}, 32'd0);
    word_ready = 1'b0;
    applyStimulus(32, 0);
    waitValid("ovf");
    sendEnd();
    end_sig = 1'b1;
    step();
    end_sig = 1'b0;
    checkOutput("ovf_set", {31'd0, ovf_err}, 32'd1);
    repeat (3) step();
    word_ready = 1'b1;
    waitIdle("ovf");
    checkOutput("ovf_sticky", {31'd0, ovf_err}, 32'd1);

    $display("[TB] reset mid-frame");
    applyStimulus(10, 1);
    repeat (4) step();
    reset = 1'b1;
    step();
    checkOutput("mid_rst_pop",   {31'd0, pop_fout},   32'd0);
    checkOutput("mid_rst_valid", {31'd0, word_valid}, 32'd0);
    checkOutput("mid_rst_last",  {31'd0, word_last},  32'd0);
    checkOutput("mid_rst_data",  word_data,           32'd0);
    checkOutput("mid_rst_busy",  {31'd0, busy},       32'd0);
    checkOutput("mid_rst_ovf",   {31'd0, ovf_err},    32'd0);
    modelReset();
    reset = 1'b0;
    step();
    waitIdle("post_rst");
    applyStimulus(3, 1);
    sendEnd();
    waitIdle("post_rst_frame");

    $display("[TB] randomized frames");
    rand_ready = 1'b1;
    for (int f = 0; f < 10; f++) begin
      applyStimulus($urandom_range(0, 80), 0);
      sendEnd();
      waitIdle("rand");
    end
    rand_ready = 1'b0;
    word_ready = 1'b1;
    checkOutput("final_exp_empty", 32'(exp_q.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checkCount, failCount);
    $finish;
  end

endmodule
